// File: rtl/inv_ark_column_feeder.sv
// rtl/inv_ark_column_feeder.sv - AES-256 decrypt AddRoundKey stage that streams state^key
// one 32-bit column per beat into InvMixColumns.
module inv_ark_column_feeder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic [3:0]       in_round,
  input  logic             in_skip_mix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_col,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic [3:0]       out_round,
  output logic             out_skip_mix,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [127:0]     data_q, data_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       round_q, round_d;
  logic             skip_q, skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_beat;
  logic             capture;
  logic [31:0]      col_sel;

  // in_ready reopens on the final accepted column so blocks chain with no bubble
  assign last_beat = (state_q == SEND) && (idx_q == 2'd3) && out_ready;
  assign in_ready  = (state_q == IDLE) || last_beat;
  assign capture   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    round_d = round_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    if (last_beat) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = IDLE;
    end else if ((state_q == SEND) && out_ready) begin
      idx_d = idx_q + 2'd1;
    end
    if (capture) begin
      data_d  = in_state ^ in_key;
      round_d = in_round;
      skip_d  = in_skip_mix;
      idx_d   = 2'd0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      round_q <= '0;
      skip_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    col_sel = 32'd0;
    case (idx_q)
      2'd0: col_sel = data_q[127:96];
      2'd1: col_sel = data_q[95:64];
      2'd2: col_sel = data_q[63:32];
      2'd3: col_sel = data_q[31:0];
      default: col_sel = 32'd0;
    endcase
  end

  // Sideband is zeroed while idle so a stale column never leaks downstream
  assign out_valid    = (state_q == SEND);
  assign out_col      = out_valid ? col_sel : 32'd0;
  assign out_idx      = out_valid ? idx_q : 2'd0;
  assign out_last     = out_valid && (idx_q == 2'd3);
  assign out_round    = out_valid ? round_q : 4'd0;
  assign out_skip_mix = out_valid && skip_q;
  assign blk_count    = cnt_q;

endmodule

// File: tb/tb_inv_ark_column_feeder.sv
// tb/tb_inv_ark_column_feeder.sv - table-driven bench for inv_ark_column_feeder (CNT_W=2).
module tb_inv_ark_column_feeder;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_state;
  logic [127:0]     in_key;
  logic [3:0]       in_round;
  logic             in_skip_mix;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_col;
  logic [1:0]       out_idx;
  logic             out_last;
  logic [3:0]       out_round;
  logic             out_skip_mix;
  logic [CNT_W-1:0] blk_count;

  inv_ark_column_feeder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key),
    .in_round(in_round), .in_skip_mix(in_skip_mix),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_idx(out_idx), .out_last(out_last),
    .out_round(out_round), .out_skip_mix(out_skip_mix),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]     state;
    logic [127:0]     key;
    logic [3:0]       round;
    logic             skip;
    logic [3:0][31:0] cols;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs [5];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input vec_t v);
    in_valid    = 1'b1;
    in_state    = v.state;
    in_key      = v.key;
    in_round    = v.round;
    in_skip_mix = v.skip;
  endtask

  task automatic check_col(input vec_t v, input int c);
    chk("out_valid", {127'd0, out_valid}, 128'd1);
    chk("out_col", {96'd0, out_col}, {96'd0, v.cols[3-c]});
    chk("out_idx", {126'd0, out_idx}, 128'(c));
    chk("out_last", {127'd0, out_last}, (c == 3) ? 128'd1 : 128'd0);
    chk("out_round", {124'd0, out_round}, {124'd0, v.round});
    chk("out_skip_mix", {127'd0, out_skip_mix}, {127'd0, v.skip});
  endtask

  initial begin
    // cols[3] is column 0 (packed MSB first)
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                4'd5, 1'b0, {32'h00102030, 32'h40506070, 32'h8090a0b0, 32'hc0d0e0f0}, 2'd1};
    vecs[1] = '{{128{1'b1}}, 128'd0,
                4'd14, 1'b1, {32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff}, 2'd2};
    vecs[2] = '{128'd0, 128'hdeadbeef0123456789abcdeffedcba98,
                4'd0, 1'b0, {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98}, 2'd3};
    vecs[3] = '{128'ha5a5a5a55a5a5a5affffffff00000000, 128'h5a5a5a5aa5a5a5a50f0f0f0ff0f0f0f0,
                4'd9, 1'b1, {32'hffffffff, 32'hffffffff, 32'hf0f0f0f0, 32'hf0f0f0f0}, 2'd0};
    vecs[4] = '{128'h123456789abcdef01111111122222222, 128'h12345678000000001111111133333333,
                4'd1, 1'b0, {32'h00000000, 32'h9abcdef0, 32'h00000000, 32'h11111111}, 2'd1};

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0;
    in_round = '0; in_skip_mix = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state and idle outputs
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_last", {127'd0, out_last}, 128'd0);
    chk("rst_out_round", {124'd0, out_round}, 128'd0);
    chk("rst_out_skip", {127'd0, out_skip_mix}, 128'd0);
    chk("rst_blk_count", {126'd0, blk_count}, 128'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_out_valid", {127'd0, out_valid}, 128'd0);
      chk("idle_out_col", {96'd0, out_col}, 128'd0);
      chk("idle_out_idx", {126'd0, out_idx}, 128'd0);
      chk("idle_in_ready", {127'd0, in_ready}, 128'd1);
    end

    // Table: one block per vector, out_ready high; blk_count walks 1,2,3,0,1
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      drive_block(vecs[v]);
      chk("tbl_in_ready_idle", {127'd0, in_ready}, 128'd1);
      step();
      in_valid = 1'b0;
      in_state = {4{$urandom}};
      in_key   = {4{$urandom}};
      for (int c = 0; c < 4; c++) begin
        check_col(vecs[v], c);
        chk("tbl_in_ready", {127'd0, in_ready}, (c == 3) ? 128'd1 : 128'd0);
        step();
      end
      chk("tbl_drain_valid", {127'd0, out_valid}, 128'd0);
      chk("tbl_blk_count", {126'd0, blk_count}, {126'd0, vecs[v].cnt});
    end

    // Back-pressure on column 1, then back-to-back second block
    drive_block(vecs[0]);
    step();
    in_valid = 1'b0;
    check_col(vecs[0], 0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_col(vecs[0], 1);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      step();
    end
    out_ready = 1'b1;
    check_col(vecs[0], 1);
    step();
    check_col(vecs[0], 2);
    step();
    check_col(vecs[0], 3);
    drive_block(vecs[1]);
    chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_blk_count", {126'd0, blk_count}, 128'd2);
    for (int c = 0; c < 4; c++) begin
      check_col(vecs[1], c);
      step();
    end
    chk("b2b_blk_count2", {126'd0, blk_count}, 128'd3);
    chk("b2b_drain_valid", {127'd0, out_valid}, 128'd0);

    // Reset mid-block after column 1 accepted; in_valid high with rst is ignored
    rst = 1'b1; step(); rst = 1'b0; step();
    drive_block(vecs[2]);
    step();
    in_valid = 1'b0;
    step();
    step();
    check_col(vecs[2], 2);
    rst = 1'b1;
    drive_block(vecs[3]);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_blk_count", {126'd0, blk_count}, 128'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_no_cols", {127'd0, out_valid}, 128'd0);
      chk("mid_rst_col_zero", {96'd0, out_col}, 128'd0);
    end
    chk("mid_rst_blk_count2", {126'd0, blk_count}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
